// File: rtl/mg_cpa_pipe.sv
// Pipelined carry-propagate adder with valid/ready flow control.
// A WIDTH-bit add is split into STAGES ripple segments of SEG = ceil(WIDTH/STAGES) bits;
// segment k works on the operand bits [k*SEG +: SEG], clipped to WIDTH. The carry between
// segments is registered. Each stage register carries the full operand words forward (input
// skew) and accumulates finished sum bits (output deskew), so all sum bits of a transaction
// leave the last stage together. Unused low bits in later stages are trimmed by synthesis.
// Optional feature: define MG_CPA_OVF_EN to add the registered signed-overflow output ovf.

module mg_cpa_pipe #(
  parameter int unsigned WIDTH  = 15,
  parameter int unsigned STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MG_CPA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SEG  = (WIDTH + STAGES - 1) / STAGES;
  localparam int          LAST = int'(STAGES) - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH) begin : gen_bad_param
    $error("mg_cpa_pipe: need WIDTH >= 2 and 1 <= STAGES <= WIDTH");
  end

  typedef logic [WIDTH-1:0] word_t;

  // Stage registers: operands travelling down, partial sum, inter-segment carry, valid
  word_t a_q [STAGES];
  word_t b_q [STAGES];
  word_t s_q [STAGES];
  logic  c_q [STAGES];
  logic  v_q [STAGES];

  // Inputs seen by each stage's segment adder
  word_t st_a [STAGES];
  word_t st_b [STAGES];
  word_t st_s [STAGES];
  logic  st_c [STAGES];
  logic  st_v [STAGES];

  // Segment adder results, loaded into the stage registers on advance
  word_t nx_s [STAGES];
  logic  nx_c [STAGES];

`ifdef MG_CPA_OVF_EN
  // Overflow flag follows the transaction once the MSB has been summed
  logic  o_q  [STAGES];
  logic  st_o [STAGES];
  logic  nx_o [STAGES];
`endif

  logic adv;

  // Whole pipe moves together; a stalled output freezes every stage
  assign adv       = !v_q[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
`ifdef MG_CPA_OVF_EN
  assign ovf       = o_q[LAST];
`endif

  // Select each stage's inputs: stage 0 takes the ports, stage k the registers of stage k-1
  always_comb begin
    st_a[0] = a;
    st_b[0] = b;
    st_s[0] = '0;
    st_c[0] = cin;
    st_v[0] = in_valid;
`ifdef MG_CPA_OVF_EN
    st_o[0] = 1'b0;
`endif
    for (int k = 1; k < int'(STAGES); k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
      st_v[k] = v_q[k-1];
`ifdef MG_CPA_OVF_EN
      st_o[k] = o_q[k-1];
`endif
    end
  end

  // Ripple segment adders using p = a^b, g = a&b over the bits owned by each stage
  always_comb begin
    logic  c;
    logic  p;
    logic  g;
    word_t s;
`ifdef MG_CPA_OVF_EN
    logic  o;
`endif
    c = 1'b0;
    p = 1'b0;
    g = 1'b0;
    s = '0;
`ifdef MG_CPA_OVF_EN
    o = 1'b0;
`endif
    for (int k = 0; k < int'(STAGES); k++) begin
      c = st_c[k];
      s = st_s[k];
`ifdef MG_CPA_OVF_EN
      o = st_o[k];
`endif
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= k * int'(SEG) && i < (k + 1) * int'(SEG)) begin
          p    = st_a[k][i] ^ st_b[k][i];
          g    = st_a[k][i] & st_b[k][i];
          s[i] = p ^ c;
`ifdef MG_CPA_OVF_EN
          // Carry into MSB xor carry out of MSB
          if (i == int'(WIDTH) - 1) o = c ^ (g | (p & c));
`endif
          c    = g | (p & c);
        end
      end
      nx_s[k] = s;
      nx_c[k] = c;
`ifdef MG_CPA_OVF_EN
      nx_o[k] = o;
`endif
    end
  end

  // Stage registers: clear on reset, load all stages on advance, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
`ifdef MG_CPA_OVF_EN
        o_q[k] <= 1'b0;
`endif
      end
    end else if (adv) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= st_a[k];
        b_q[k] <= st_b[k];
        s_q[k] <= nx_s[k];
        c_q[k] <= nx_c[k];
        v_q[k] <= st_v[k];
`ifdef MG_CPA_OVF_EN
        o_q[k] <= nx_o[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mg_cpa_pipe.sv
// Self-checking bench for mg_cpa_pipe: directed steps with a result scoreboard, plus
// side instances with other WIDTH/STAGES settings for latency and full-carry checks.

module tb_mg_cpa_pipe;

  localparam int W = 15;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef MG_CPA_OVF_EN
  logic         ovf;
  logic [3:0]   e_ovf;
  logic         e4_ovf;
`endif

  always #5 clk = ~clk;

  mg_cpa_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef MG_CPA_OVF_EN
    , .ovf(ovf)
`endif
  );

  // Side instances: (15,1), (15,4), (15,15), (32,5)
  logic        x_valid, x_cin;
  logic [14:0] x_a15;
  logic [31:0] x_a32;
  logic [14:0] e_sum [3];
  logic [31:0] e4_sum;
  logic [3:0]  e_ov, e_co, e_ir;

  mg_cpa_pipe #(.WIDTH(15), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(e_ir[0]), .a(x_a15), .b(15'd0),
    .cin(x_cin), .out_valid(e_ov[0]), .out_ready(1'b1), .sum(e_sum[0]), .cout(e_co[0])
`ifdef MG_CPA_OVF_EN
    , .ovf(e_ovf[0])
`endif
  );

  mg_cpa_pipe #(.WIDTH(15), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(e_ir[1]), .a(x_a15), .b(15'd0),
    .cin(x_cin), .out_valid(e_ov[1]), .out_ready(1'b1), .sum(e_sum[1]), .cout(e_co[1])
`ifdef MG_CPA_OVF_EN
    , .ovf(e_ovf[1])
`endif
  );

  mg_cpa_pipe #(.WIDTH(15), .STAGES(15)) dut_s15 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(e_ir[2]), .a(x_a15), .b(15'd0),
    .cin(x_cin), .out_valid(e_ov[2]), .out_ready(1'b1), .sum(e_sum[2]), .cout(e_co[2])
`ifdef MG_CPA_OVF_EN
    , .ovf(e_ovf[2])
`endif
  );

  mg_cpa_pipe #(.WIDTH(32), .STAGES(5)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(e_ir[3]), .a(x_a32), .b(32'd0),
    .cin(x_cin), .out_valid(e_ov[3]), .out_ready(1'b1), .sum(e4_sum), .cout(e_co[3])
`ifdef MG_CPA_OVF_EN
    , .ovf(e4_ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_in = 0;
  int           n_out = 0;
  logic         ov_s, co_s;
  logic [W-1:0] sum_s;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_c;
  logic [3:0]   e_ov_s, e_co_s;
  logic [14:0]  e_sum_s [3];
  logic [31:0]  e4_sum_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer add, overflow from operand/result sign bits
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t       e;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  // One clock: sample at negedge, check, score, then move to just after the next posedge
  task automatic step();
    exp_t e;
    @(negedge clk);
    ov_s     = out_valid;
    sum_s    = sum;
    co_s     = cout;
    e_ov_s   = e_ov;
    e_co_s   = e_co;
    e_sum_s  = e_sum;
    e4_sum_s = e4_sum;
    check("in_ready", in_ready, !out_valid || out_ready);
    if (hold_v) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {cout, sum}, {hold_c, hold_sum});
    end
    hold_v   = out_valid && !out_ready;
    hold_sum = sum;
    hold_c   = cout;
    if (out_valid && out_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_out++;
        check("sb_result", {cout, sum}, {e.c, e.s});
`ifdef MG_CPA_OVF_EN
        check("sb_ovf", ovf, e.o);
`endif
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(a, b, cin));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = ci;
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 4) step();
  endtask

  initial begin
    int n;
    int lat [4];
    int base;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    x_valid   = 1'b0;
    x_cin     = 1'b0;
    x_a15     = '0;
    x_a32     = '0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", {cout, sum}, 0);
`ifdef MG_CPA_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // 1: latency and simple sum
    send(15'h0001, 15'h0002, 1'b0);
    in_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!ov_s && n < 20);
    check("t1_latency", n, S);
    check("t1_sum", {co_s, sum_s}, {1'b0, 15'h0003});
    drain();

    // 2: full-chain carry, then signed overflow
    send(15'h7FFF, 15'h0000, 1'b1);
    send(15'h3FFF, 15'h0001, 1'b0);
    drain();

    // 3: back-to-back random stream
    base = n_out;
    for (int i = 0; i < 100; i++) send(W'($urandom()), W'($urandom()), 1'($urandom()));
    drain();
    check("t3_count", n_out - base, 100);

    // 4: random backpressure and bubbles
    for (int i = 0; i < 200; i++) begin
      out_ready = 1'($urandom());
      in_valid  = ($urandom_range(3) != 0);
      a         = W'($urandom());
      b         = W'($urandom());
      cin       = 1'($urandom());
      step();
    end
    drain();
    check("t4_in_out", n_out, n_in);

    // 5: asynchronous reset with a stalled result at the output
    out_ready = 1'b0;
    send(15'h1111, 15'h2222, 1'b0);
    send(15'h0F0F, 15'h00F0, 1'b1);
    in_valid = 1'b0;
    step();
    step();
    check("t5_stalled_valid", ov_s, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ready", in_ready, 1);
    sb.delete();
    hold_v = 1'b0;
    #7 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    send(15'h1234, 15'h0100, 1'b1);
    in_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!ov_s && n < 20);
    check("t5_first_sum", {co_s, sum_s}, {1'b0, 15'h1335});
    drain();

    // 6: other geometries, all-ones + 0 + cin
    x_a15   = '1;
    x_a32   = '1;
    x_cin   = 1'b1;
    x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    for (int j = 0; j < 4; j++) lat[j] = -1;
    for (int k = 1; k <= 25; k++) begin
      step();
      for (int j = 0; j < 3; j++) begin
        if (e_ov_s[j] && lat[j] < 0) begin
          lat[j] = k;
          check($sformatf("sweep%0d_sum", j), {e_co_s[j], e_sum_s[j]}, {1'b1, 15'h0000});
        end
      end
      if (e_ov_s[3] && lat[3] < 0) begin
        lat[3] = k;
        check("sweep3_sum", {e_co_s[3], e4_sum_s}, {1'b1, 32'h0});
      end
    end
    check("sweep0_latency", lat[0], 1);
    check("sweep1_latency", lat[1], 4);
    check("sweep2_latency", lat[2], 15);
    check("sweep3_latency", lat[3], 5);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
